fetch_seq: RTL and testbench
============================

// Module: fetch_seq
// PURPOSE
//  Fetch sequencer owning the program counter. Issues one instruction-memory request at a time
//  with a req/gnt/rvalid handshake and presents fetched instructions to decode with valid/stall.
//  Applies redirects (taken branch or jump target computed by next-PC logic) and cancels stale
//  in-flight fetches. Sits between the next-PC logic and instruction memory.
// PARAMETERS
//  RESET_PC  30'h00000C00  word address (PC[31:2]) fetched first after reset (byte 0x3000)
// PORTS
//  clk            in   1   clock, all state on rising edge
//  rst_n          in   1   asynchronous active-low reset
//  stall          in   1   decode cannot accept; hold presented instruction
//  redirect_valid in   1   next PC is non-sequential this cycle
//  redirect_pc    in   30  redirect word address [31:2]
//  imem_req       out  1   fetch request (registered)
//  imem_addr      out  30  fetch word address [31:2]; stable while imem_req && !imem_gnt
//  imem_gnt       in   1   memory accepted request this cycle
//  imem_rvalid    in   1   read data valid; earliest 1 cycle after gnt
//  imem_rdata     in   32  instruction word
//  inst_valid     out  1   inst/inst_pc valid (registered)
//  inst           out  32  instruction to decode
//  inst_pc        out  30  word address of inst
//  proto_err      out  1   sticky: rvalid received with no fetch outstanding
// BEHAVIOUR
//  - Reset: state=BOOT, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=0,
//    inst_pc=0, proto_err=0. Reset may assert in any state; in-flight responses are lost.
//  - States: BOOT, REQ, WAIT, OUT, KILL. BOOT->REQ unconditionally after 1 cycle.
//  - REQ: imem_req=1, imem_addr=req_addr (latched from pc on entry). gnt -> WAIT.
//  - WAIT: await imem_rvalid. rvalid -> inst<=rdata, inst_pc<=req_addr, inst_valid<=1,
//    pc<=req_addr+1 (30-bit, 0x3FFFFFFF wraps to 0), -> OUT.
//  - OUT: inst_valid=1, outputs held. !stall -> inst_valid<=0, -> REQ at pc. stall -> stay.
//    Instruction consumed on the cycle inst_valid && !stall. Min 3 cycles/instruction.
//  - KILL: await rvalid of cancelled fetch; discard data (inst_* untouched), -> REQ at pc.
//  - Redirect (priority over stall, sequential increment and rvalid capture), pc<=redirect_pc:
//    BOOT -> REQ; REQ with or without gnt -> request already issued/pending completes at old
//      address (addr held until gnt), then KILL; gnt same cycle -> KILL directly;
//    WAIT, no rvalid -> KILL; WAIT with rvalid -> data discarded, -> REQ;
//    OUT -> inst_valid<=0 same edge, -> REQ; KILL -> stay KILL, pc overwritten (last wins).
//  - REQ pending-kill: a redirect during REQ without gnt sets kill flag; on gnt -> KILL.
//  - rvalid in BOOT/REQ/OUT: ignored, proto_err<=1 (cleared only by reset).
//  - gnt outside REQ ignored. imem_addr never changes while imem_req=1 and gnt not seen.
// STRUCTURE
//  - Shared include fetch_defs.vh: state encodings (BOOT..KILL, 3-bit), RESET_PC default.
//  - Sub-module pc_reg: 30-bit register, async active-low reset to RESET_PC, load enable,
//    select increment vs redirect_pc. Rest (FSM, output regs, kill flag) in fetch_seq.
// TESTING
//  1 Reset release, gnt immediate, rvalid 1 cycle later, rdata=0x20080005, stall=0 ->
//    imem_addr=0xC00, inst_valid 1 cycle with inst_pc=0xC00, next req addr=0xC01.
//  2 stall=1 for 4 cycles while OUT -> inst/inst_pc/inst_valid constant; no imem_req until
//    stall drops; next request addr=inst_pc+1.
//  3 redirect_pc=0x00000100 in WAIT, rvalid 2 cycles later with 0xDEADBEEF -> data never
//    presented; next imem_addr=0x100.
//  4 gnt held low 5 cycles, redirect_pc=0x200 in cycle 2 -> imem_addr stays old value until
//    gnt, response discarded, next request addr=0x200.
//  5 pc=0x3FFFFFFF fetch completes -> next imem_addr=0x0; redirect+stall same cycle in OUT ->
//    inst_valid drops, request at redirect_pc.
//  6 rvalid pulse in OUT with no request outstanding -> proto_err=1 and sticky; rst_n low
//    mid-WAIT -> all outputs to reset values asynchronously, restart fetch at 0xC00.

Source files
------------

// File: rtl/fetch_seq_pkg.sv
// Shared fetch-sequencer definitions: FSM state encoding, default boot PC and PC arithmetic.
package fetch_seq_pkg;

   typedef enum logic [2:0] {
      ST_BOOT = 3'd0,
      ST_REQ  = 3'd1,
      ST_WAIT = 3'd2,
      ST_OUT  = 3'd3,
      ST_KILL = 3'd4
   } state_t;

   // Word address [31:2]; byte address 0x3000.
   localparam logic [29:0] RESET_PC_DEF = 30'h00000C00;

   function automatic logic [29:0] pc_inc(input logic [29:0] pc);
      return pc + 30'd1;
   endfunction

endpackage

// File: rtl/fetch_seq_pc_reg.sv
// Program-counter register: loads either the sequential increment or a redirect target.
// o_pc_nxt exposes the value the register takes on the coming edge (same-cycle use by the FSM).
module fetch_seq_pc_reg
   import fetch_seq_pkg::*;
#(
   parameter logic [29:0] RESET_PC = RESET_PC_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_load,
   input  logic        i_sel_redir,
   input  logic [29:0] i_redir_pc,
   output logic [29:0] o_pc,
   output logic [29:0] o_pc_nxt
);

   logic [29:0] r_pc;

   always_comb begin
      o_pc_nxt = r_pc;
      if (i_load) begin
         o_pc_nxt = i_sel_redir ? i_redir_pc : pc_inc(r_pc);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc <= RESET_PC;
      end else begin
         r_pc <= o_pc_nxt;
      end
   end

   assign o_pc = r_pc;

endmodule

// File: rtl/fetch_seq.sv
// Fetch sequencer: one outstanding imem request, presents instructions to decode (min 3 cycles/inst).
// Decode stall holds the presented instruction; redirects cancel in-flight fetches via KILL.
module fetch_seq
   import fetch_seq_pkg::*;
#(
   parameter logic [29:0] RESET_PC = RESET_PC_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [29:0] redirect_pc,
   output logic        imem_req,
   output logic [29:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [29:0] inst_pc,
   output logic        proto_err
);

   state_t      r_state, w_state_nxt;
   logic        r_kill, w_kill_nxt;
   logic        r_req;
   logic [29:0] r_req_addr;
   logic        r_inst_vld;
   logic [31:0] r_inst;
   logic [29:0] r_inst_pc;
   logic        r_perr;
   logic        w_pc_load, w_pc_redir, w_capture, w_perr_set;
   logic [29:0] w_pc, w_pc_nxt;

   fetch_seq_pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_load      (w_pc_load),
      .i_sel_redir (w_pc_redir),
      .i_redir_pc  (redirect_pc),
      .o_pc        (w_pc),
      .o_pc_nxt    (w_pc_nxt)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_kill_nxt  = r_kill;
      w_pc_load   = 1'b0;
      w_pc_redir  = 1'b0;
      w_capture   = 1'b0;
      w_perr_set  = 1'b0;
      if (redirect_valid) begin
         w_pc_load  = 1'b1;
         w_pc_redir = 1'b1;
      end
      case (r_state)
         ST_BOOT: begin
            w_state_nxt = ST_REQ;
            w_perr_set  = imem_rvalid;
         end
         ST_REQ: begin
            w_perr_set = imem_rvalid;
            // A redirect cannot withdraw an issued request; remember it and drain via KILL.
            if (imem_gnt) begin
               w_state_nxt = (r_kill || redirect_valid) ? ST_KILL : ST_WAIT;
               w_kill_nxt  = 1'b0;
            end else if (redirect_valid) begin
               w_kill_nxt = 1'b1;
            end
         end
         ST_WAIT: begin
            if (imem_rvalid) begin
               if (redirect_valid) begin
                  w_state_nxt = ST_REQ;
               end else begin
                  w_state_nxt = ST_OUT;
                  w_capture   = 1'b1;
                  w_pc_load   = 1'b1;
               end
            end else if (redirect_valid) begin
               w_state_nxt = ST_KILL;
            end
         end
         ST_OUT: begin
            w_perr_set = imem_rvalid;
            if (redirect_valid || !stall) begin
               w_state_nxt = ST_REQ;
            end
         end
         ST_KILL: begin
            if (imem_rvalid) begin
               w_state_nxt = ST_REQ;
            end
         end
         default: w_state_nxt = ST_BOOT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_BOOT;
         r_kill     <= 1'b0;
         r_req      <= 1'b0;
         r_req_addr <= RESET_PC;
         r_inst_vld <= 1'b0;
         r_inst     <= 32'd0;
         r_inst_pc  <= 30'd0;
         r_perr     <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_kill  <= w_kill_nxt;
         r_req   <= (w_state_nxt == ST_REQ);
         // Address is latched only on REQ entry so it stays stable until the grant.
         if ((w_state_nxt == ST_REQ) && (r_state != ST_REQ)) begin
            r_req_addr <= w_pc_nxt;
         end
         if (w_capture) begin
            r_inst     <= imem_rdata;
            r_inst_pc  <= r_req_addr;
            r_inst_vld <= 1'b1;
         end else if ((r_state == ST_OUT) && (w_state_nxt != ST_OUT)) begin
            r_inst_vld <= 1'b0;
         end
         if (w_perr_set) begin
            r_perr <= 1'b1;
         end
      end
   end

   assign imem_req   = r_req;
   assign imem_addr  = r_req_addr;
   assign inst_valid = r_inst_vld;
   assign inst       = r_inst;
   assign inst_pc    = r_inst_pc;
   assign proto_err  = r_perr;

endmodule

// File: tb/tb_fetch_seq.sv
// Directed vector table for the corner cases, then randomized memory/decode traffic
// checked against a transaction-level model of the expected instruction stream.
module tb_fetch_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall;
   logic        redirect_valid;
   logic [29:0] redirect_pc;
   logic        imem_req;
   logic [29:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic [31:0] inst;
   logic [29:0] inst_pc;
   logic        proto_err;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   fetch_seq dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .inst_valid     (inst_valid),
      .inst           (inst),
      .inst_pc        (inst_pc),
      .proto_err      (proto_err)
   );

   typedef struct packed {
      logic        stall;
      logic        redir;
      logic [29:0] rpc;
      logic        gnt;
      logic        rvld;
      logic [31:0] rdata;
      logic        e_req;
      logic [29:0] e_addr;
      logic        e_iv;
      logic [31:0] e_inst;
      logic [29:0] e_ipc;
      logic        e_perr;
   } vec_t;

   vec_t vt [0:28];

   function automatic vec_t mk(input logic s, input logic r, input logic [29:0] rp,
                               input logic g, input logic rv, input logic [31:0] rd,
                               input logic ereq, input logic [29:0] eaddr, input logic eiv,
                               input logic [31:0] einst, input logic [29:0] eipc, input logic eperr);
      vec_t v;
      v.stall = s;   v.redir = r;     v.rpc = rp;  v.gnt = g;     v.rvld = rv;   v.rdata = rd;
      v.e_req = ereq; v.e_addr = eaddr; v.e_iv = eiv; v.e_inst = einst; v.e_ipc = eipc; v.e_perr = eperr;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic chk_outputs(input string tag, input logic ereq, input logic [29:0] eaddr,
                              input logic eiv, input logic [31:0] einst, input logic [29:0] eipc,
                              input logic eperr);
      chk({tag, "_req"},   {31'd0, imem_req},   {31'd0, ereq});
      chk({tag, "_addr"},  {2'd0, imem_addr},   {2'd0, eaddr});
      chk({tag, "_ivld"},  {31'd0, inst_valid}, {31'd0, eiv});
      chk({tag, "_inst"},  inst,                einst);
      chk({tag, "_ipc"},   {2'd0, inst_pc},     {2'd0, eipc});
      chk({tag, "_perr"},  {31'd0, proto_err},  {31'd0, eperr});
   endtask

   // Memory contents as seen by the bench: an arbitrary fixed scramble of the address.
   function automatic logic [31:0] memf(input logic [29:0] a);
      return {a[13:0], a[29:12]} ^ 32'h5EED1234;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset release with immediate grant, 4-cycle stall, redirect in WAIT, gnt withheld with
      // redirect, proto_err in OUT, redirect+stall in OUT, PC wrap at 0x3FFFFFFF.
      vt[0]  = mk(0,0,30'h0,0,0,32'h0,          0,30'hC00,0,32'h0,30'h0,0);
      vt[1]  = mk(0,0,30'h0,1,0,32'h0,          1,30'hC00,0,32'h0,30'h0,0);
      vt[2]  = mk(0,0,30'h0,0,1,32'h20080005,   0,30'hC00,0,32'h0,30'h0,0);
      vt[3]  = mk(1,0,30'h0,0,0,32'h0,          0,30'hC00,1,32'h20080005,30'hC00,0);
      vt[4]  = mk(1,0,30'h0,0,0,32'h0,          0,30'hC00,1,32'h20080005,30'hC00,0);
      vt[5]  = mk(1,0,30'h0,0,0,32'h0,          0,30'hC00,1,32'h20080005,30'hC00,0);
      vt[6]  = mk(1,0,30'h0,0,0,32'h0,          0,30'hC00,1,32'h20080005,30'hC00,0);
      vt[7]  = mk(0,0,30'h0,0,0,32'h0,          0,30'hC00,1,32'h20080005,30'hC00,0);
      vt[8]  = mk(0,0,30'h0,1,0,32'h0,          1,30'hC01,0,32'h20080005,30'hC00,0);
      vt[9]  = mk(0,1,30'h100,0,0,32'h0,        0,30'hC01,0,32'h20080005,30'hC00,0);
      vt[10] = mk(0,0,30'h0,0,0,32'h0,          0,30'hC01,0,32'h20080005,30'hC00,0);
      vt[11] = mk(0,0,30'h0,0,1,32'hDEADBEEF,   0,30'hC01,0,32'h20080005,30'hC00,0);
      vt[12] = mk(0,0,30'h0,0,0,32'h0,          1,30'h100,0,32'h20080005,30'hC00,0);
      vt[13] = mk(0,1,30'h200,0,0,32'h0,        1,30'h100,0,32'h20080005,30'hC00,0);
      vt[14] = mk(0,0,30'h0,0,0,32'h0,          1,30'h100,0,32'h20080005,30'hC00,0);
      vt[15] = mk(0,0,30'h0,0,0,32'h0,          1,30'h100,0,32'h20080005,30'hC00,0);
      vt[16] = mk(0,0,30'h0,0,0,32'h0,          1,30'h100,0,32'h20080005,30'hC00,0);
      vt[17] = mk(0,0,30'h0,1,0,32'h0,          1,30'h100,0,32'h20080005,30'hC00,0);
      vt[18] = mk(0,0,30'h0,0,1,32'h12345678,   0,30'h100,0,32'h20080005,30'hC00,0);
      vt[19] = mk(0,0,30'h0,1,0,32'h0,          1,30'h200,0,32'h20080005,30'hC00,0);
      vt[20] = mk(0,0,30'h0,0,1,32'hA5A5A5A5,   0,30'h200,0,32'h20080005,30'hC00,0);
      vt[21] = mk(1,0,30'h0,0,1,32'hFFFFFFFF,   0,30'h200,1,32'hA5A5A5A5,30'h200,0);
      vt[22] = mk(1,1,30'h3FFFFFFF,0,0,32'h0,   0,30'h200,1,32'hA5A5A5A5,30'h200,1);
      vt[23] = mk(0,0,30'h0,1,0,32'h0,          1,30'h3FFFFFFF,0,32'hA5A5A5A5,30'h200,1);
      vt[24] = mk(0,0,30'h0,0,1,32'h0BADF00D,   0,30'h3FFFFFFF,0,32'hA5A5A5A5,30'h200,1);
      vt[25] = mk(0,0,30'h0,0,0,32'h0,          0,30'h3FFFFFFF,1,32'h0BADF00D,30'h3FFFFFFF,1);
      vt[26] = mk(0,0,30'h0,0,0,32'h0,          1,30'h0,0,32'h0BADF00D,30'h3FFFFFFF,1);
      vt[27] = mk(0,0,30'h0,1,0,32'h0,          1,30'h0,0,32'h0BADF00D,30'h3FFFFFFF,1);
      vt[28] = mk(0,0,30'h0,0,0,32'h0,          0,30'h0,0,32'h0BADF00D,30'h3FFFFFFF,1);

      rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
      repeat (2) @(negedge clk);
      chk_outputs("reset", 0, 30'hC00, 0, 32'h0, 30'h0, 0);
      rst_n = 1'b1;

      for (int i = 0; i <= 28; i++) begin
         chk_outputs($sformatf("v%0d", i), vt[i].e_req, vt[i].e_addr, vt[i].e_iv,
                     vt[i].e_inst, vt[i].e_ipc, vt[i].e_perr);
         stall          = vt[i].stall;
         redirect_valid = vt[i].redir;
         redirect_pc    = vt[i].rpc;
         imem_gnt       = vt[i].gnt;
         imem_rvalid    = vt[i].rvld;
         imem_rdata     = vt[i].rdata;
         @(negedge clk);
      end

      // Asynchronous reset in the middle of a WAIT, then fetch restarts from the boot PC.
      #2 rst_n = 1'b0;
      #1 chk_outputs("async_rst", 0, 30'hC00, 0, 32'h0, 30'h0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      chk_outputs("boot", 0, 30'hC00, 0, 32'h0, 30'h0, 0);
      @(negedge clk);
      chk_outputs("restart", 1, 30'hC00, 0, 32'h0, 30'h0, 0);

      begin
         logic [29:0] exp_pc, cur_pc, paddr, prev_addr;
         logic        pend, prev_req, prev_gnt, prev_iv, prev_stall, prev_redir;
         int          pcnt, n_pres;
         exp_pc = 30'hC00; cur_pc = '0; paddr = '0; prev_addr = '0;
         pend = 1'b0; pcnt = 0; n_pres = 0;
         prev_req = 1'b0; prev_gnt = 1'b0; prev_iv = 1'b0; prev_stall = 1'b0; prev_redir = 1'b0;
         for (int cyc = 0; cyc < 4000; cyc++) begin
            chk("rnd_perr", {31'd0, proto_err}, 32'd0);
            if (prev_req && !prev_gnt) begin
               chk("rnd_req_hold", {31'd0, imem_req}, 32'd1);
               chk("rnd_addr_hold", {2'd0, imem_addr}, {2'd0, prev_addr});
            end
            if (prev_iv && (!prev_stall || prev_redir)) begin
               chk("rnd_ivld_drop", {31'd0, inst_valid}, 32'd0);
            end
            if (inst_valid && !prev_iv) begin
               cur_pc = exp_pc;
               n_pres++;
               chk("rnd_ipc", {2'd0, inst_pc}, {2'd0, cur_pc});
               chk("rnd_inst", inst, memf(cur_pc));
            end else if (inst_valid) begin
               chk("rnd_ipc_held", {2'd0, inst_pc}, {2'd0, cur_pc});
               chk("rnd_inst_held", inst, memf(cur_pc));
            end

            stall          = ($urandom_range(0, 9) < 3);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc    = ($urandom_range(0, 7) == 0) ? 30'h3FFFFFFF : 30'($urandom);
            imem_gnt       = $urandom_range(0, 1) == 1;
            imem_rvalid    = 1'b0;
            imem_rdata     = $urandom;
            if (pend) begin
               if (pcnt == 0) begin
                  imem_rvalid = 1'b1;
                  imem_rdata  = memf(paddr);
                  pend = 1'b0;
               end else begin
                  pcnt--;
               end
            end
            if (imem_req && imem_gnt) begin
               chk("rnd_one_outstanding", {31'd0, pend}, 32'd0);
               pend  = 1'b1;
               paddr = imem_addr;
               pcnt  = $urandom_range(0, 2);
            end

            if (inst_valid && !stall && !redirect_valid) exp_pc = cur_pc + 30'd1;
            if (redirect_valid) exp_pc = redirect_pc;

            prev_req = imem_req; prev_gnt = imem_gnt; prev_addr = imem_addr;
            prev_iv = inst_valid; prev_stall = stall; prev_redir = redirect_valid;
            @(negedge clk);
         end
         chk("rnd_throughput", {31'd0, (n_pres >= 100)}, 32'd1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
